paralelo_serie_param: RTL and testbench

PARALELO_SERIE_PARAM -- requirements
Module: paralelo_serie_param

---
 rtl/paralelo_serie_param.sv | 136 +++++++++++++
 tb/tb_paralelo_serie_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serie_param.sv
// ---------------------------------------------------------------------------
// paralelo_serie_param
//
// Parallel-to-serial converter. A WIDTH-bit word is captured when the block
// is ready and a load is requested. It is then sent one bit per clock, MSB or
// LSB first, optionally followed by one even or odd parity bit. Because the
// block is ready again during the final bit of a frame, words can be streamed
// back to back with no idle cycle between frames.
//
// Parameters
//   WIDTH     : parallel word width (>= 2)
//   LSB_FIRST : 0 = MSB sent first, 1 = LSB sent first
//   PARITY    : 0 = none, 1 = even, 2 = odd (bit sent after the data)
//
// Ports
//   clk     : single clock, all logic on the rising edge
//   clr     : synchronous active-high reset, overrides any load request
//   ena_in  : load request, a word is taken when ena_in and ready are both high
//   in      : parallel word, sampled only at the accepting edge
//   out     : serial data bit (registered)
//   ena_out : high on every cycle in which out carries a frame bit (registered)
//   last    : high with the final bit of a frame (registered)
//   ready   : the block can accept a word in this cycle
// ---------------------------------------------------------------------------
module paralelo_serie_param #(
    parameter int WIDTH     = 6,
    parameter int LSB_FIRST = 0,
    parameter int PARITY    = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena_in,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             ena_out,
    output logic             last,
    output logic             ready
);

    localparam int            CW           = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);
    localparam bit            HAS_PARITY   = (PARITY != 0);
    localparam bit            ODD_PARITY   = (PARITY == 2);

    // PAR is only ever entered when a parity bit is configured.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             par_bit, par_n;
    logic             out_n, ena_n, last_n;

    // The final-bit cycle is exactly the cycle in which the registered last
    // flag is high, so it can double as the "frame finishing" indication.
    assign ready = (state == IDLE) || last;

    // Next-state logic. cnt holds the index of the data bit currently on out.
    // shreg keeps the full word and is shifted so that the next bit to send
    // is always found next to the end the first bit was taken from.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        out_n   = 1'b0;
        ena_n   = 1'b0;
        last_n  = 1'b0;

        if (ready) begin
            if (ena_in) begin
                state_n = SHIFT;
                cnt_n   = '0;
                shreg_n = in;
                par_n   = (^in) ^ ODD_PARITY;
                out_n   = (LSB_FIRST != 0) ? in[0] : in[WIDTH-1];
                ena_n   = 1'b1;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
                par_n   = 1'b0;
            end
        end else if (state == SHIFT) begin
            if (cnt != LAST_IDX) begin
                if (LSB_FIRST != 0) begin
                    shreg_n = shreg >> 1;
                    out_n   = shreg[1];
                end else begin
                    shreg_n = shreg << 1;
                    out_n   = shreg[WIDTH-2];
                end
                cnt_n  = cnt + CW'(1);
                ena_n  = 1'b1;
                last_n = !HAS_PARITY && (cnt == PRE_LAST_IDX);
            end else begin
                // Without parity the last data bit already raised ready, so
                // reaching here means the parity bit is due.
                state_n = PAR;
                cnt_n   = '0;
                out_n   = par_bit;
                ena_n   = 1'b1;
                last_n  = 1'b1;
            end
        end else begin
            state_n = IDLE;
        end
    end

    // State and output registers; clr wins over everything, including a load.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            out     <= 1'b0;
            ena_out <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            out     <= out_n;
            ena_out <= ena_n;
            last    <= last_n;
        end
    end

endmodule

// File: tb/tb_paralelo_serie_param.sv
// ---------------------------------------------------------------------------
// tb_paralelo_serie_param
//
// Drives four instances of paralelo_serie_param (WIDTH=6) with different bit
// orders and parity modes. Each instance is compared every cycle against a
// model that keeps the list of serial bits still owed to the line. The model
// treats the block as ready whenever at most one bit is still owed.
// ---------------------------------------------------------------------------
module tb_paralelo_serie_param;

    localparam int W  = 6;
    localparam int ND = 4;
    localparam int LSB_CFG [ND] = '{0, 1, 0, 1};
    localparam int PAR_CFG [ND] = '{0, 0, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] clr, ena_in, dout, ena_out, last, ready;
    logic [W-1:0]  din [ND];

    paralelo_serie_param #(.WIDTH(W), .LSB_FIRST(LSB_CFG[0]), .PARITY(PAR_CFG[0])) dut0 (
        .clk(clk), .clr(clr[0]), .ena_in(ena_in[0]), .in(din[0]),
        .out(dout[0]), .ena_out(ena_out[0]), .last(last[0]), .ready(ready[0]));
    paralelo_serie_param #(.WIDTH(W), .LSB_FIRST(LSB_CFG[1]), .PARITY(PAR_CFG[1])) dut1 (
        .clk(clk), .clr(clr[1]), .ena_in(ena_in[1]), .in(din[1]),
        .out(dout[1]), .ena_out(ena_out[1]), .last(last[1]), .ready(ready[1]));
    paralelo_serie_param #(.WIDTH(W), .LSB_FIRST(LSB_CFG[2]), .PARITY(PAR_CFG[2])) dut2 (
        .clk(clk), .clr(clr[2]), .ena_in(ena_in[2]), .in(din[2]),
        .out(dout[2]), .ena_out(ena_out[2]), .last(last[2]), .ready(ready[2]));
    paralelo_serie_param #(.WIDTH(W), .LSB_FIRST(LSB_CFG[3]), .PARITY(PAR_CFG[3])) dut3 (
        .clk(clk), .clr(clr[3]), .ena_in(ena_in[3]), .in(din[3]),
        .out(dout[3]), .ena_out(ena_out[3]), .last(last[3]), .ready(ready[3]));

    // Bits each instance still owes to the serial line, oldest first.
    logic exp_bit [ND][16];
    int   exp_n   [ND];

    int n_cmp = 0;
    int n_bad = 0;

    // Serial capture of instance 0, used for the literal stream checks.
    bit          rec_on   = 1'b0;
    logic [15:0] rec_bits = '0;
    int          rec_cnt  = 0;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Advance one instance's model by one clock edge.
    task automatic modelEdge(input int d);
        logic     rdy;
        logic     pb;
        logic [W-1:0] v;
        rdy = (exp_n[d] <= 1);
        if (exp_n[d] > 0) begin
            for (int k = 0; k < 15; k++) exp_bit[d][k] = exp_bit[d][k+1];
            exp_n[d]--;
        end
        if (clr[d]) begin
            exp_n[d] = 0;
        end else if (ena_in[d] && rdy) begin
            v = din[d];
            for (int i = 0; i < W; i++) begin
                exp_bit[d][exp_n[d]] = (LSB_CFG[d] != 0) ? v[i] : v[W-1-i];
                exp_n[d]++;
            end
            if (PAR_CFG[d] != 0) begin
                pb = (($countones(v) % 2) == 1);
                if (PAR_CFG[d] == 2) pb = ~pb;
                exp_bit[d][exp_n[d]] = pb;
                exp_n[d]++;
            end
        end
    endtask

    // One clock: update the models at the edge, then check every instance.
    task automatic tick();
        logic [3:0] want;
        @(posedge clk);
        for (int d = 0; d < ND; d++) modelEdge(d);
        #1;
        for (int d = 0; d < ND; d++) begin
            if (exp_n[d] == 0) want = 4'b0001;
            else want = {1'b1, exp_bit[d][0], exp_n[d] == 1, exp_n[d] == 1};
            checkOutput($sformatf("dut%0d {ena_out,out,last,ready}", d),
                        {28'd0, ena_out[d], dout[d], last[d], ready[d]}, {28'd0, want});
        end
        if (rec_on && ena_out[0]) begin
            rec_bits = {rec_bits[14:0], dout[0]};
            rec_cnt++;
        end
    endtask

    // Same inputs to every instance for one clock.
    task automatic applyStimulus(input logic c, input logic e, input logic [W-1:0] v);
        clr    = {ND{c}};
        ena_in = {ND{e}};
        for (int d = 0; d < ND; d++) din[d] = v;
        tick();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, W'($urandom));
    endtask

    task automatic startRecord();
        rec_on   = 1'b1;
        rec_bits = '0;
        rec_cnt  = 0;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) exp_n[d] = 0;
        clr    = '1;
        ena_in = '0;
        for (int d = 0; d < ND; d++) din[d] = '0;

        // Reset, including a word presented together with clr.
        applyStimulus(1'b1, 1'b0, 6'b000000);
        applyStimulus(1'b1, 1'b1, 6'b111111);
        idleCycles(2);

        // Single frame, data changing on in after the accept.
        startRecord();
        applyStimulus(1'b0, 1'b1, 6'b101100);
        idleCycles(9);
        rec_on = 1'b0;
        checkOutput("single frame bits", {26'd0, rec_bits[5:0]}, 32'b101100);
        checkOutput("single frame count", rec_cnt, 6);

        // Back-to-back frames with ena_in held.
        startRecord();
        applyStimulus(1'b0, 1'b1, 6'b111000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 6'b000111);
        idleCycles(14);
        rec_on = 1'b0;
        checkOutput("back-to-back bits", {20'd0, rec_bits[11:0]}, 32'b111000000111);
        checkOutput("back-to-back count", rec_cnt, 12);

        // Load request while busy is ignored.
        startRecord();
        applyStimulus(1'b0, 1'b1, 6'b000000);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 6'b111111);
        idleCycles(12);
        rec_on = 1'b0;
        checkOutput("busy reject bits", {16'd0, rec_bits}, 32'd0);
        checkOutput("busy reject count", rec_cnt, 6);

        // Reset mid-frame, then a fresh word.
        applyStimulus(1'b0, 1'b1, 6'b101100);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 6'b000000);
        startRecord();
        applyStimulus(1'b0, 1'b1, 6'b110101);
        idleCycles(9);
        rec_on = 1'b0;
        checkOutput("after abort bits", {26'd0, rec_bits[5:0]}, 32'b110101);
        checkOutput("after abort count", rec_cnt, 6);

        // Random traffic, independent per instance.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < ND; d++) begin
                clr[d]    = ($urandom_range(0, 39) == 0);
                ena_in[d] = ($urandom_range(0, 3) != 0);
                din[d]    = W'($urandom);
            end
            tick();
        end
        idleCycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
